// File: rtl/bist_controller.sv
// BIST session controller: sequences reset/run/flush of the LFSR->scan_reg->MISR path
// and compares the captured MISR signature against a golden value.
module bist_controller #(
  parameter int unsigned           WIDTH        = 4,
  parameter int unsigned           NUM_PATTERNS = 15,
  parameter int unsigned           INIT_CYCLES  = 2,
  parameter int unsigned           FLUSH_CYCLES = 1,
  parameter logic [WIDTH-1:0]      GOLDEN_SIG   = '0,
  localparam int unsigned          CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] misr_signature,
  output logic             core_rstn,
  output logic             bist_mode,
  output logic             scan_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature_q,
  output logic [CNT_W-1:0] pattern_cnt
);

  localparam int unsigned PH_MAX0 = (INIT_CYCLES > NUM_PATTERNS) ? INIT_CYCLES : NUM_PATTERNS;
  localparam int unsigned PH_MAX  = (FLUSH_CYCLES > PH_MAX0) ? FLUSH_CYCLES : PH_MAX0;
  localparam int unsigned PH_W    = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    CMP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [PH_W-1:0]   phase_cnt, phase_nxt;
  logic [CNT_W-1:0]  pattern_nxt;
  logic [WIDTH-1:0]  sig_nxt;
  logic              pass_nxt;
  logic              core_rstn_nxt, bist_mode_nxt, busy_nxt, done_nxt;

  // State, counters and all outputs are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      pattern_cnt <= '0;
      signature_q <= '0;
      pass        <= 1'b0;
      core_rstn   <= 1'b0;
      bist_mode   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase_cnt   <= phase_nxt;
      pattern_cnt <= pattern_nxt;
      signature_q <= sig_nxt;
      pass        <= pass_nxt;
      core_rstn   <= core_rstn_nxt;
      bist_mode   <= bist_mode_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  assign scan_en = 1'b0;

  // Next-state, counter and output decode.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase_cnt;
    pattern_nxt = pattern_cnt;
    sig_nxt     = signature_q;
    pass_nxt    = pass;

    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    if (32'(phase_cnt) == INIT_CYCLES - 1) state_nxt = RUN;
      RUN:     if (32'(phase_cnt) == NUM_PATTERNS - 1)
                 state_nxt = (FLUSH_CYCLES == 0) ? CMP : FLUSH;
      FLUSH:   if (32'(phase_cnt) == FLUSH_CYCLES - 1) state_nxt = CMP;
      CMP:     state_nxt = DONE;
      DONE:    if (start) state_nxt = INIT;
      default: state_nxt = IDLE;
    endcase

    // abort wins over start, including a start request seen in IDLE
    if (abort) state_nxt = IDLE;

    if (state_nxt != state) phase_nxt = '0;
    else if (state inside {INIT, RUN, FLUSH}) phase_nxt = phase_cnt + PH_W'(1);

    if (state_nxt == INIT && state != INIT) pattern_nxt = '0;
    else if (state == RUN && !abort && pattern_cnt != CNT_W'(NUM_PATTERNS))
      pattern_nxt = pattern_cnt + CNT_W'(1);

    if (state == CMP && state_nxt == DONE) begin
      sig_nxt  = misr_signature;
      pass_nxt = (misr_signature == GOLDEN_SIG);
    end else if (state_nxt inside {IDLE, INIT}) begin
      pass_nxt = 1'b0;
    end

    core_rstn_nxt = state_nxt inside {RUN, FLUSH, CMP, DONE};
    bist_mode_nxt = state_nxt inside {RUN, FLUSH};
    busy_nxt      = state_nxt inside {INIT, RUN, FLUSH, CMP};
    done_nxt      = (state_nxt == DONE);
  end

endmodule
